pc_cmd_frame_rx: RTL and testbench
==================================

// Module: pc_cmd_frame_rx
// PURPOSE
//  Front end of the PC command path. Receives a raw byte stream from the PC
//  link and validates framing: SOF, length, payload and XOR checksum.
//  A payload is released as a byte stream to the configuration parser
//  (pc_cmd_valid/pc_cmd_data) only after its checksum passes.
//  Corrupt, truncated or stalled frames are dropped and counted.
// PARAMETERS
//  MAX_PAYLOAD     16      max payload bytes per frame; payload buffer depth
//  TIMEOUT_CYCLES  1000    idle clk cycles allowed between bytes inside a frame
//  SOF_BYTE        8'hA5   start-of-frame marker
//  ERR_CNT_W       16      width of the saturating error counter
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous reset, active-high
//  rx_valid     in   1          PC byte valid
//  rx_data      in   8          PC byte
//  rx_ready     out  1          byte accepted when rx_valid && rx_ready
//  cmd_valid    out  1          payload byte valid toward config parser
//  cmd_data     out  8          payload byte
//  cmd_ready    in   1          parser accepts byte when cmd_valid && cmd_ready
//  frame_ok     out  1          1-cycle pulse: good frame fully drained
//  err_chk      out  1          1-cycle pulse: checksum mismatch
//  err_len      out  1          1-cycle pulse: LEN==0 or LEN>MAX_PAYLOAD
//  err_timeout  out  1          1-cycle pulse: inter-byte timeout
//  err_count    out  ERR_CNT_W  total errors, saturates at all-ones
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  - Frame format: SOF, LEN, LEN payload bytes, CHK.
//    Checksum rule: CHK == LEN ^ payload[0] ^ ... ^ payload[LEN-1].
//  - Reset state: IDLE. All outputs 0 except rx_ready=1. Pointers, checksum
//    and timeout counter are cleared. Reset mid-frame or mid-drain discards
//    the frame with no error pulse.
//  - IDLE: a byte == SOF_BYTE moves to LEN. Any other byte is silently dropped.
//  - LEN: a byte of 0 or >MAX_PAYLOAD pulses err_len and returns to IDLE.
//    Otherwise it stores len, sets chk=byte, wr_ptr=0 and moves to PAYLOAD.
//  - PAYLOAD: each byte is written to buf[wr_ptr] and XORed into chk.
//    After the len-th byte, moves to CHK.
//  - CHK: a byte == chk moves to DRAIN with rd_ptr=0. A mismatch pulses
//    err_chk and returns to IDLE.
//  - DRAIN: rx_ready=0 and cmd_valid=1 with cmd_data=buf[rd_ptr].
//    * On each handshake rd_ptr increments.
//    * The last handshake pulses frame_ok the following cycle and returns
//      to IDLE.
//    * cmd_valid/cmd_data are registered. First cmd_valid is asserted the
//      cycle after CHK is accepted. With cmd_ready=1, throughput is
//      1 byte/cycle.
//    * cmd_data holds stable while cmd_valid && !cmd_ready.
//  - rx_ready=1 in IDLE, LEN, PAYLOAD and CHK.
//  - Timeout: the counter runs in LEN/PAYLOAD/CHK and clears on each accepted
//    byte. When TIMEOUT_CYCLES consecutive cycles pass without an accepted
//    byte, err_timeout pulses and the state returns to IDLE. No timeout
//    applies in DRAIN; parser backpressure is unbounded.
//  - A SOF_BYTE inside LEN/PAYLOAD/CHK is treated as data, with no resync.
//  - err_count increments by 1 on any err_* pulse. At most one err_* pulse
//    occurs per cycle. The counter holds at 2^ERR_CNT_W-1.
//  - Pointer widths are $clog2(MAX_PAYLOAD+1); no wrap occurs within a frame.
// STRUCTURE
//  - Shared package pc_link_pkg holds:
//    * SOF_BYTE default
//    * state encoding IDLE/LEN/PAYLOAD/CHK/DRAIN
//    * error-code constants shared with the config parser
//  - Sub-module cmd_payload_buf: MAX_PAYLOAD x 8 register array with
//    write port (wr_en, wr_ptr) and read port (rd_ptr), combinational read.
//  - FSM, checksum, timeout counter and error counter stay in this module.
// TESTING
//  - Good frame A5 03 11 22 33 CHK=03^11^22^33=03, cmd_ready=1:
//    cmd_data 11,22,33 on 3 consecutive cycles, then frame_ok=1, err_count=0.
//  - Same frame with CHK=04: no cmd_valid, err_chk pulses once, err_count=1,
//    busy=0. A following good frame is then delivered.
//  - LEN=00 and LEN=11 (17>16): err_len each time, err_count=2, no output.
//  - A5 02 7E then 1000 idle cycles: err_timeout on cycle 1000, state IDLE.
//    Next A5 01 55 54 delivers 55.
//  - Good 4-byte frame with cmd_ready toggling 1,0,0,1,...: every byte
//    delivered once in order, rx_ready=0 throughout DRAIN.
//  - Assert rst mid-PAYLOAD and mid-DRAIN: outputs return to reset values
//    immediately, no error pulse, err_count=0.

Source files
------------

// File: rtl/pc_link_pkg.sv
// Shared definitions for the PC command link: framing constants, receiver
// state encoding and the error codes the config parser also understands.
package pc_link_pkg;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CHK     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload holding buffer: one synchronous write port, one combinational read port.
module cmd_payload_buf #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == PTR_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    // Out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PTR_W'(i)) rd_data = mem[i];
        end
    end

endmodule

// File: rtl/pc_cmd_frame_rx.sv
// PC command frame receiver: validates SOF/LEN/payload/XOR checksum and
// releases the payload to the config parser only once the frame checks out.
//   state   | meaning
//   IDLE    | hunting for SOF, other bytes dropped
//   LEN     | waiting for length byte
//   PAYLOAD | storing payload bytes, accumulating checksum
//   CHK     | comparing checksum byte
//   DRAIN   | presenting buffered payload to the parser
module pc_cmd_frame_rx
    import pc_link_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEF,
    parameter int         ERR_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_data,
    input  logic                 cmd_ready,
    output logic                 frame_ok,
    output logic                 err_chk,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int               PTR_W    = $clog2(MAX_PAYLOAD + 1);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    rx_state_e        state;
    err_code_e        err_evt;
    logic [PTR_W-1:0] len;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_addr;
    logic [7:0]       chk;
    logic [7:0]       rd_data;
    logic [TMR_W-1:0] tmr;
    logic             rx_fire;
    logic             cmd_fire;
    logic             in_frame;
    logic             len_bad;
    logic             buf_wr_en;

    assign rx_ready  = (state != ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign rx_fire   = rx_valid && rx_ready;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_frame  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign len_bad   = (rx_data == 8'd0) || (rx_data > 8'(MAX_PAYLOAD));
    assign buf_wr_en = (state == ST_PAYLOAD) && rx_fire;

    // Look one entry ahead so the registered cmd_data can advance every cycle
    assign rd_addr = (state == ST_DRAIN) ? rd_ptr + PTR_W'(1) : '0;

    cmd_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_ptr  (wr_ptr),
        .wr_data (rx_data),
        .rd_ptr  (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        err_evt = ERR_NONE;
        if (in_frame && !rx_fire && tmr == '0) begin
            err_evt = ERR_TIMEOUT;
        end else if (rx_fire && state == ST_LEN && len_bad) begin
            err_evt = ERR_LEN;
        end else if (rx_fire && state == ST_CHK && rx_data != chk) begin
            err_evt = ERR_CHK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            chk         <= '0;
            tmr         <= '0;
            cmd_valid   <= 1'b0;
            cmd_data    <= '0;
            frame_ok    <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_ok    <= 1'b0;
            err_chk     <= (err_evt == ERR_CHK);
            err_len     <= (err_evt == ERR_LEN);
            err_timeout <= (err_evt == ERR_TIMEOUT);

            if (err_evt != ERR_NONE && err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end

            // Down-counter reloads on every accepted byte; terminal count is zero
            if (rx_fire) begin
                tmr <= TMR_LOAD;
            end else if (in_frame && tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
            end

            if (err_evt != ERR_NONE) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_fire && rx_data == SOF_BYTE) state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_fire) begin
                            len    <= PTR_W'(rx_data);
                            chk    <= rx_data;
                            wr_ptr <= '0;
                            state  <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx_fire) begin
                            chk    <= chk ^ rx_data;
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (wr_ptr == len - PTR_W'(1)) state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (rx_fire) begin
                            rd_ptr    <= '0;
                            cmd_valid <= 1'b1;
                            cmd_data  <= rd_data;
                            state     <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (cmd_fire) begin
                            if (rd_ptr == len - PTR_W'(1)) begin
                                cmd_valid <= 1'b0;
                                frame_ok  <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                rd_ptr   <= rd_ptr + PTR_W'(1);
                                cmd_data <= rd_data;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_cmd_frame_rx.sv
// Directed bench for pc_cmd_frame_rx: vector table of whole frames plus
// hand-written timeout and reset sequences.
module tb_pc_cmd_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        frame_ok;
    logic        err_chk;
    logic        err_len;
    logic        err_timeout;
    logic [15:0] err_count;
    logic        busy;

    pc_cmd_frame_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .frame_ok    (frame_ok),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // cmd_ready modes: 0 = always 1, 1 = repeating 1,0,0,1, 2 = always 0
    int ready_mode = 0;
    int ridx = 0;

    // Monitor state, sampled on the falling edge
    int         cyc = 0;
    int         last_rx_cyc = 0;
    int         v_rise_cyc = 0;
    int         fok_cyc = 0;
    int         out_n = 0;
    logic [7:0] out_log [256];
    int         out_cyc [256];
    int         n_ok = 0, n_chk = 0, n_len = 0, n_tmo = 0;
    int         viol_rxr = 0, viol_stab = 0;
    logic       prev_v = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid && rx_ready) last_rx_cyc = cyc;
        if (cmd_valid && !prev_v) v_rise_cyc = cyc;
        if (cmd_valid && cmd_ready && out_n < 256) begin
            out_log[out_n] = cmd_data;
            out_cyc[out_n] = cyc;
            out_n++;
        end
        if (cmd_valid && rx_ready) viol_rxr++;
        if (prev_stall && cmd_valid && cmd_data != prev_data) viol_stab++;
        prev_stall = cmd_valid && !cmd_ready;
        prev_data  = cmd_data;
        prev_v     = cmd_valid;
        if (frame_ok) begin
            n_ok++;
            fok_cyc = cyc;
        end
        if (err_chk)     n_chk++;
        if (err_len)     n_len++;
        if (err_timeout) n_tmo++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic next_ready();
        logic [3:0] pat;
        pat = 4'b1001;
        case (ready_mode)
            1:       return pat[3 - (ridx % 4)];
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        ridx++;
        cmd_ready = next_ready();
    endtask

    typedef struct {
        int           n;
        logic [159:0] raw;
        int           mode;
        int           exp_n;
        logic [127:0] exp;
        int           exp_ok;
        int           exp_chk;
        int           exp_len;
        int           exp_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input int k);
        vec_t v;
        int   o0, ok0, chk0, len0, tmo0, rxc, t;
        v    = vecs[k];
        o0   = out_n;
        ok0  = n_ok;
        chk0 = n_chk;
        len0 = n_len;
        tmo0 = n_tmo;
        ready_mode = v.mode;
        ridx = 0;
        cmd_ready = next_ready();
        for (int i = 0; i < v.n; i++) begin
            rx_valid = 1'b1;
            rx_data  = v.raw[8*(v.n-1-i) +: 8];
            step();
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rxc = last_rx_cyc;
        t = 0;
        while (busy && t < 200) begin
            step();
            t++;
        end
        if (busy) check($sformatf("v%0d_drain_budget", k), 1, 0);
        step();
        step();
        check($sformatf("v%0d_out_count", k), out_n - o0, v.exp_n);
        for (int i = 0; i < v.exp_n; i++) begin
            check($sformatf("v%0d_out_byte%0d", k, i), int'(out_log[o0+i]), int'(v.exp[8*(v.exp_n-1-i) +: 8]));
        end
        check($sformatf("v%0d_frame_ok", k), n_ok - ok0, v.exp_ok);
        check($sformatf("v%0d_err_chk", k), n_chk - chk0, v.exp_chk);
        check($sformatf("v%0d_err_len", k), n_len - len0, v.exp_len);
        check($sformatf("v%0d_err_timeout", k), n_tmo - tmo0, 0);
        check($sformatf("v%0d_err_count", k), int'(err_count), v.exp_cnt);
        check($sformatf("v%0d_busy", k), int'(busy), 0);
        if (v.exp_ok == 1 && v.exp_n > 0 && out_n - o0 == v.exp_n) begin
            check($sformatf("v%0d_first_valid_lat", k), v_rise_cyc, rxc + 1);
            check($sformatf("v%0d_frame_ok_lat", k), fok_cyc, out_cyc[out_n-1] + 1);
            if (v.mode == 0) begin
                check($sformatf("v%0d_back_to_back", k), out_cyc[out_n-1] - out_cyc[o0], v.exp_n - 1);
            end
        end
    endtask

    initial begin
        int t, ok0, chk0, len0, tmo0;

        vecs[0]  = '{6,  160'hA5_03_11_22_33_03, 0, 3, 128'h11_22_33, 1, 0, 0, 0};
        vecs[1]  = '{6,  160'hA5_03_11_22_33_04, 0, 0, 128'h0,         0, 1, 0, 1};
        vecs[2]  = '{6,  160'hA5_03_11_22_33_03, 0, 3, 128'h11_22_33, 1, 0, 0, 1};
        vecs[3]  = '{2,  160'hA5_00,             0, 0, 128'h0,         0, 0, 1, 2};
        vecs[4]  = '{2,  160'hA5_11,             0, 0, 128'h0,         0, 0, 1, 3};
        vecs[5]  = '{19, 160'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_00, 0,
                     16, 128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10, 1, 0, 0, 3};
        vecs[6]  = '{6,  160'h00_FF_A5_01_A5_A4, 0, 1, 128'hA5,        1, 0, 0, 3};
        vecs[7]  = '{7,  160'hA5_04_DE_AD_BE_EF_26, 1, 4, 128'hDE_AD_BE_EF, 1, 0, 0, 3};
        vecs[8]  = '{4,  160'hA5_01_5A_00,       0, 0, 128'h0,         0, 1, 0, 4};
        vecs[9]  = '{4,  160'hA5_01_55_54,       0, 1, 128'h55,        1, 0, 0, 5};
        vecs[10] = '{4,  160'hA5_01_77_76,       0, 1, 128'h77,        1, 0, 0, 0};

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        cmd_ready = 1'b1;
        #1;
        check("rst_rx_ready", int'(rx_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_data", int'(cmd_data), 0);
        check("rst_frame_ok", int'(frame_ok), 0);
        check("rst_errs", int'({err_chk, err_len, err_timeout}), 0);
        check("rst_err_count", int'(err_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        for (int k = 0; k <= 8; k++) run_vec(k);

        // Inter-byte timeout: pulse on exactly the 1000th idle cycle
        tmo0 = n_tmo;
        ready_mode = 0;
        foreach (vecs[0].raw[i]) begin end
        rx_valid = 1'b1; rx_data = 8'hA5; step();
        rx_data = 8'h02; step();
        rx_data = 8'h7E; step();
        rx_valid = 1'b0; rx_data = 8'h00;
        repeat (999) step();
        check("tmo_not_early", int'(err_timeout), 0);
        check("tmo_busy_before", int'(busy), 1);
        step();
        check("tmo_pulse", int'(err_timeout), 1);
        check("tmo_idle", int'(busy), 0);
        check("tmo_err_count", int'(err_count), 5);
        step();
        check("tmo_single_pulse", n_tmo - tmo0, 1);
        check("tmo_pulse_cleared", int'(err_timeout), 0);

        run_vec(9);

        // Reset in the middle of PAYLOAD
        ok0 = n_ok; chk0 = n_chk; len0 = n_len; tmo0 = n_tmo;
        rx_valid = 1'b1; rx_data = 8'hA5; step();
        rx_data = 8'h04; step();
        rx_data = 8'h11; step();
        rx_data = 8'h22; step();
        rx_valid = 1'b0; rx_data = 8'h00;
        check("mid_payload_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_payload_busy", int'(busy), 0);
        check("rst_payload_rx_ready", int'(rx_ready), 1);
        check("rst_payload_err_count", int'(err_count), 0);
        step();
        rst = 1'b0;
        repeat (3) step();

        // Reset in the middle of DRAIN while the parser stalls
        ready_mode = 2;
        cmd_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hA5; step();
        rx_data = 8'h02; step();
        rx_data = 8'h12; step();
        rx_data = 8'h34; step();
        rx_data = 8'h24; step();
        rx_valid = 1'b0; rx_data = 8'h00;
        t = 0;
        while (!cmd_valid && t < 20) begin
            step();
            t++;
        end
        check("drain_valid", int'(cmd_valid), 1);
        check("drain_data", int'(cmd_data), 8'h12);
        check("drain_rx_ready", int'(rx_ready), 0);
        repeat (3) step();
        check("drain_hold", int'(cmd_data), 8'h12);
        rst = 1'b1;
        #1;
        check("rst_drain_valid", int'(cmd_valid), 0);
        check("rst_drain_busy", int'(busy), 0);
        check("rst_drain_rx_ready", int'(rx_ready), 1);
        check("rst_drain_cmd_data", int'(cmd_data), 0);
        step();
        rst = 1'b0;
        ready_mode = 0;
        repeat (3) step();
        check("rst_no_frame_ok", n_ok - ok0, 0);
        check("rst_no_err_pulse", (n_chk - chk0) + (n_len - len0) + (n_tmo - tmo0), 0);
        check("rst_err_count_zero", int'(err_count), 0);

        run_vec(10);

        check("rx_ready_low_in_drain", viol_rxr, 0);
        check("cmd_data_stable_on_stall", viol_stab, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
